syscall_controller: RTL and testbench

Sequences MIPS `syscall` execution for the pipelined core. When a syscall sits in Decode and the hazard unit reports `$v0`/`$a0` settled, the block captures both registers and freezes the pipeline. It then services the call by streaming characters to the console port, reading string bytes through the data-memory byte port when needed, or halting the core. Afterwards it releases the pipeline so the syscall can retire.

---
 rtl/syscall_pkg.sv | 27 ++
 rtl/syscall_controller_dec_digit_gen.sv | 62 ++++++
 rtl/syscall_controller.sv | 140 ++++++++++++++
 tb/tb_syscall_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/syscall_pkg.sv
// Shared constants, state encoding and helpers for the syscall sequencer.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [3:0] {
    IDLE, DECODE, STR_RD, STR_WAIT, STR_EMIT,
    INT_SIGN, INT_DIGIT, INT_EMIT, CHAR_EMIT, DONE, HALT
  } state_t;

  localparam logic [31:0] POW10 [10] = '{
    32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
    32'd10000, 32'd1000, 32'd100, 32'd10, 32'd1
  };

  // Two's-complement magnitude; 0x80000000 maps to 2147483648 unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/syscall_controller_dec_digit_gen.sv
// Serial decimal digit generator: repeated subtraction of powers of ten,
// most significant first, with leading-zero suppression.
import syscall_pkg::*;

module dec_digit_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic [31:0] mag,
  output logic [3:0]  digit,
  output logic        valid,
  output logic        last
);

  logic [31:0] rem;
  logic [3:0]  idx;
  logic [3:0]  acc;
  logic        started;
  logic        active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      idx     <= '0;
      acc     <= '0;
      started <= 1'b0;
      active  <= 1'b0;
      digit   <= '0;
      valid   <= 1'b0;
      last    <= 1'b0;
    end else if (start) begin
      rem     <= mag;
      idx     <= '0;
      acc     <= '0;
      started <= 1'b0;
      active  <= 1'b1;
      valid   <= 1'b0;
      last    <= 1'b0;
    end else if (!stall) begin
      // valid lasts one unstalled cycle: the parent consumes it on that edge
      valid <= 1'b0;
      if (active) begin
        if (rem >= POW10[idx]) begin
          rem <= rem - POW10[idx];
          acc <= acc + 4'd1;
        end else begin
          if (acc != '0 || started || idx == 4'd9) begin
            valid   <= 1'b1;
            digit   <= acc;
            last    <= (idx == 4'd9);
            started <= 1'b1;
          end
          if (idx == 4'd9) active <= 1'b0;
          else             idx    <= idx + 4'd1;
          acc <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/syscall_controller.sv
// Syscall sequencer: captures $v0/$a0, freezes the pipeline and services
// print_int / print_string / print_char / exit over the console port.
import syscall_pkg::*;

module syscall_controller #(
  parameter int unsigned MAX_STR_LEN = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        syscall_d,
  input  logic        sysstall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_byte,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic        stall_sys,
  output logic        busy_mem,
  output logic        halt,
  output logic        bad_sys
);

  state_t      state;
  logic [31:0] v0_q, a0_q, ptr, cnt;
  logic        last_q;
  logic [3:0]  digit;
  logic        digit_valid, digit_last;
  logic        xfer;

  assign xfer      = cons_valid && cons_ready;
  assign mem_rd    = (state == STR_RD);
  assign busy_mem  = (state == STR_RD) || (state == STR_WAIT);
  assign mem_addr  = ptr;
  assign stall_sys = (state == IDLE) ? syscall_d : (state != DONE);

  dec_digit_gen u_digits (
    .clk   (clk),
    .rst_n (rst_n),
    .start ((state == DECODE) && (v0_q == SYS_PRINT_INT)),
    .stall (state != INT_DIGIT),
    .mag   (magnitude(a0_q)),
    .digit (digit),
    .valid (digit_valid),
    .last  (digit_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      v0_q       <= '0;
      a0_q       <= '0;
      ptr        <= '0;
      cnt        <= '0;
      last_q     <= 1'b0;
      cons_valid <= 1'b0;
      cons_data  <= '0;
      halt       <= 1'b0;
      bad_sys    <= 1'b0;
    end else begin
      bad_sys <= 1'b0;
      unique case (state)
        IDLE: if (syscall_d && !sysstall) begin
          v0_q  <= v0;
          a0_q  <= a0;
          state <= DECODE;
        end
        DECODE: begin
          case (v0_q)
            SYS_PRINT_STR: begin
              ptr   <= a0_q;
              cnt   <= '0;
              state <= STR_RD;
            end
            SYS_PRINT_INT: begin
              if (a0_q[31]) begin
                cons_valid <= 1'b1;
                cons_data  <= ASCII_MINUS;
              end
              state <= INT_SIGN;
            end
            SYS_PRINT_CHAR: begin
              cons_valid <= 1'b1;
              cons_data  <= a0_q[7:0];
              state      <= CHAR_EMIT;
            end
            SYS_EXIT: begin
              halt  <= 1'b1;
              state <= HALT;
            end
            default: begin
              bad_sys <= 1'b1;
              state   <= DONE;
            end
          endcase
        end
        STR_RD: state <= STR_WAIT;
        STR_WAIT: begin
          if (mem_byte == 8'h00 || cnt == MAX_STR_LEN) begin
            state <= DONE;
          end else begin
            cons_data  <= mem_byte;
            cons_valid <= 1'b1;
            state      <= STR_EMIT;
          end
        end
        STR_EMIT: if (xfer) begin
          cons_valid <= 1'b0;
          ptr        <= ptr + 32'd1;
          cnt        <= cnt + 32'd1;
          state      <= STR_RD;
        end
        INT_SIGN: if (!cons_valid || xfer) begin
          cons_valid <= 1'b0;
          state      <= INT_DIGIT;
        end
        INT_DIGIT: if (digit_valid) begin
          cons_data  <= ASCII_ZERO + {4'b0000, digit};
          cons_valid <= 1'b1;
          last_q     <= digit_last;
          state      <= INT_EMIT;
        end
        INT_EMIT: if (xfer) begin
          cons_valid <= 1'b0;
          state      <= last_q ? DONE : INT_DIGIT;
        end
        CHAR_EMIT: if (xfer) begin
          cons_valid <= 1'b0;
          state      <= DONE;
        end
        DONE:    state <= IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_controller.sv
// Directed bench for syscall_controller: console transcript, memory address
// trace, release latency and backpressure stability against fixed expectations.
module tb_syscall_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        syscall_d, sysstall;
  logic [31:0] v0, a0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic        stall_sys, busy_mem, halt, bad_sys;

  syscall_controller #(.MAX_STR_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .syscall_d  (syscall_d),
    .sysstall   (sysstall),
    .v0         (v0),
    .a0         (a0),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_byte   (mem_byte),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .cons_ready (cons_ready),
    .stall_sys  (stall_sys),
    .busy_mem   (busy_mem),
    .halt       (halt),
    .bad_sys    (bad_sys)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // 1 KiB byte memory with one-cycle read latency
  logic [7:0] mem [0:1023];
  always @(posedge clk) if (mem_rd) mem_byte <= mem[mem_addr[9:0]];

  logic [7:0]  rx[$];
  logic [31:0] addrs[$];
  int unsigned bad_cnt = 0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0]  prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", cons_valid, 1'b1);
        check("hold_data", cons_data, prev_data);
      end
      if (cons_valid && cons_ready) rx.push_back(cons_data);
      if (mem_rd) addrs.push_back(mem_addr);
      if (bad_sys) bad_cnt++;
      prev_valid = cons_valid;
      prev_ready = cons_ready;
      prev_data  = cons_data;
    end
  end

  task automatic expect_rx(input string tag, input string s);
    check({tag, "_len"}, rx.size(), s.len());
    for (int i = 0; i < s.len(); i++)
      if (i < rx.size()) check({tag, "_ch"}, rx[i], s[i]);
    rx.delete();
  endtask

  // Returns the negedge index (from issue) at which the pipeline is released or halted.
  task automatic run_sys(input string tag, input logic [31:0] code, input logic [31:0] arg,
                         input int unsigned hold, output int unsigned cycles);
    bit seen = 1'b0;
    cycles = 0;
    @(posedge clk); #1;
    v0 = code; a0 = arg; syscall_d = 1'b1; sysstall = (hold != 0);
    for (int unsigned n = 1; n <= 3000 && !seen; n++) begin
      @(negedge clk);
      if (n == hold + 1) sysstall = 1'b0;
      if (!stall_sys || halt) begin
        seen = 1'b1;
        cycles = n;
        syscall_d = 1'b0;
      end
    end
    syscall_d = 1'b0;
    sysstall  = 1'b0;
    check({tag, "_release"}, seen, 1'b1);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd"}, mem_rd, 1'b0);
    check({tag, "_mem_addr"}, mem_addr, 32'h0);
    check({tag, "_cons_valid"}, cons_valid, 1'b0);
    check({tag, "_cons_data"}, cons_data, 8'h00);
    check({tag, "_stall_sys"}, stall_sys, 1'b0);
    check({tag, "_busy_mem"}, busy_mem, 1'b0);
    check({tag, "_halt"}, halt, 1'b0);
    check({tag, "_bad_sys"}, bad_sys, 1'b0);
  endtask

  int unsigned cyc;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h48; mem[10'h101] = 8'h69; mem[10'h102] = 8'h00;
    mem[10'h200] = 8'h41; mem[10'h201] = 8'h42; mem[10'h202] = 8'h43;
    mem[10'h203] = 8'h44; mem[10'h204] = 8'h45; mem[10'h205] = 8'h46;
    mem[10'h3FF] = 8'h5A; mem[10'h000] = 8'h21; mem[10'h001] = 8'h00;

    rst_n = 1'b0; syscall_d = 1'b0; sysstall = 1'b0;
    v0 = '0; a0 = '0; cons_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;

    run_sys("char", 32'd11, 32'h41, 0, cyc);
    check("char_latency", cyc, 4);
    expect_rx("char", "A");

    addrs.delete();
    run_sys("str", 32'd4, 32'h100, 0, cyc);
    check("str_latency", cyc, 11);
    expect_rx("str", "Hi");
    check("str_addr_cnt", addrs.size(), 3);
    if (addrs.size() == 3) begin
      check("str_addr0", addrs[0], 32'h100);
      check("str_addr1", addrs[1], 32'h101);
      check("str_addr2", addrs[2], 32'h102);
    end

    run_sys("int0", 32'd1, 32'd0, 0, cyc);
    expect_rx("int0", "0");
    run_sys("intmin", 32'd1, 32'h8000_0000, 0, cyc);
    expect_rx("intmin", "-2147483648");
    run_sys("int1000", 32'd1, 32'd1000, 0, cyc);
    expect_rx("int1000", "1000");
    run_sys("intneg7", 32'd1, 32'hFFFF_FFF9, 0, cyc);
    expect_rx("intneg7", "-7");

    fork
      run_sys("bp", 32'd4, 32'h100, 0, cyc);
      begin
        for (int k = 0; k < 200 && rx.size() < 1; k++) @(negedge clk);
        @(posedge clk); #1 cons_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 cons_ready = 1'b1;
      end
    join
    expect_rx("bp", "Hi");

    run_sys("hazard", 32'd11, 32'h42, 3, cyc);
    check("hazard_latency", cyc, 7);
    expect_rx("hazard", "B");

    bad_cnt = 0;
    run_sys("bad", 32'd99, 32'h0, 0, cyc);
    check("bad_latency", cyc, 3);
    check("bad_pulses", bad_cnt, 1);
    expect_rx("bad", "");

    run_sys("maxlen", 32'd4, 32'h200, 0, cyc);
    expect_rx("maxlen", "ABCD");

    addrs.delete();
    run_sys("wrap", 32'd4, 32'hFFFF_FFFF, 0, cyc);
    expect_rx("wrap", "Z!");
    check("wrap_addr_cnt", addrs.size(), 3);
    if (addrs.size() == 3) begin
      check("wrap_addr0", addrs[0], 32'hFFFF_FFFF);
      check("wrap_addr1", addrs[1], 32'h0);
      check("wrap_addr2", addrs[2], 32'h1);
    end

    run_sys("exit", 32'd10, 32'h0, 0, cyc);
    check("exit_latency", cyc, 3);
    repeat (5) @(posedge clk);
    #1;
    check("halt_sticky", halt, 1'b1);
    check("halt_stall", stall_sys, 1'b1);
    expect_rx("exit", "");
    rst_n = 1'b0;
    #1 check("halt_cleared", halt, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Abort a string stuck on backpressure with reset
    rx.delete();
    @(posedge clk); #1;
    cons_ready = 1'b0; v0 = 32'd4; a0 = 32'h100; syscall_d = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_valid", cons_valid, 1'b1);
    check("mid_data", cons_data, 8'h48);
    rst_n = 1'b0; syscall_d = 1'b0;
    #1 check_all_zero("abort");
    @(posedge clk); #1 rst_n = 1'b1; cons_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_resume", cons_valid, 1'b0);
    expect_rx("abort", "");

    run_sys("after", 32'd11, 32'h43, 0, cyc);
    check("after_latency", cyc, 4);
    expect_rx("after", "C");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
